// File: rtl/clk_divider_bank.sv
// Bank of NUM_CH independent 50%-duty clock dividers with glitch-free runtime reprogramming.
// Optional macro CLK_DIV_TICK_EN adds div_tick, a one-cycle pulse on each rising output edge.
module clk_divider_bank #(
    parameter int NUM_CH      = 4,
    parameter int CW          = 8,
    parameter int DEFAULT_DIV = 8,
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    // Handshake: a config word transfers on a rising edge where cfg_valid && cfg_ready.
    // cfg_ready depends only on cfg_ch and the pending state, never on cfg_valid.
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [CW-1:0]     cfg_div,
    output logic [NUM_CH-1:0] div_clk_out,
`ifdef CLK_DIV_TICK_EN
    output logic [NUM_CH-1:0] div_tick,
`endif
    output logic [NUM_CH-1:0] cfg_pending
);

    // Out-of-range channel indices keep ready high so the request is swallowed.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CHW'(i)) cfg_ready = ~cfg_pending[i];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [CW-1:0] act_div;
        logic [CW-1:0] shd_div;
        logic          clk_q;
        logic          pend_q;
        logic          run;
        logic          at_last;
        logic          xfer_hit;

        assign run      = ch_en[i] && (act_div != '0);
        assign at_last  = (cnt == act_div - CW'(1));
        assign xfer_hit = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));

        always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) begin
                cnt     <= '0;
                act_div <= CW'(DEFAULT_DIV);
                shd_div <= CW'(DEFAULT_DIV);
                clk_q   <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                if (!run) begin
                    cnt   <= '0;
                    clk_q <= 1'b0;
                    if (pend_q) begin
                        act_div <= shd_div;
                        pend_q  <= 1'b0;
                    end
                end else if (at_last) begin
                    cnt   <= '0;
                    clk_q <= ~clk_q;
                    // Only the end of the high phase is a full-period boundary.
                    if (clk_q && pend_q) begin
                        act_div <= shd_div;
                        pend_q  <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                // Ready is low while pending, so this never overlaps an apply.
                if (xfer_hit) begin
                    shd_div <= cfg_div;
                    pend_q  <= 1'b1;
                end
            end
        end

        assign div_clk_out[i] = clk_q;
        assign cfg_pending[i] = pend_q;

`ifdef CLK_DIV_TICK_EN
        logic tick_q;

        always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= run && at_last && !clk_q;
            end
        end

        assign div_tick[i] = tick_q;
`endif
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: period/duty, boundary-aligned reprogramming,
// stopped-channel apply, div=1, div=0, async reset and (with CLK_DIV_TICK_EN) div_tick.
module tb_clk_divider_bank;

    localparam int NUM_CH = 4;
    localparam int CW     = 8;
    localparam int CHW    = 2;

    logic              clk_50M;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHW-1:0]    cfg_ch;
    logic [CW-1:0]     cfg_div;
    logic [NUM_CH-1:0] div_clk_out;
    logic [NUM_CH-1:0] cfg_pending;
`ifdef CLK_DIV_TICK_EN
    logic [NUM_CH-1:0] div_tick;
`endif

    int checks   = 0;
    int failures = 0;

    clk_divider_bank #(.NUM_CH(NUM_CH), .CW(CW), .DEFAULT_DIV(8)) dut (
        .clk_50M     (clk_50M),
        .rst_n       (rst_n),
        .ch_en       (ch_en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .div_clk_out (div_clk_out),
`ifdef CLK_DIV_TICK_EN
        .div_tick    (div_tick),
`endif
        .cfg_pending (cfg_pending)
    );

    // Clock/reset block
    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish (got running, want done)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: all called at a falling edge and return at a falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_50M);
            @(negedge clk_50M);
        end
    endtask

    task automatic cfg_write(input int ch, input int div);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_div   = CW'(div);
        #1;
        check("cfg_ready_before_write", 64'(cfg_ready), 64'd1);
        @(posedge clk_50M);
        @(negedge clk_50M);
        cfg_valid = 1'b0;
    endtask

    // Bit k of each vector is the sample taken after the (k+1)-th rising edge.
    task automatic capture(input int ch, input int n, output logic [63:0] ov,
                           output logic [63:0] pv, output logic [63:0] tv,
                           output logic others);
        ov = '0; pv = '0; tv = '0; others = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_50M);
            @(negedge clk_50M);
            ov[k] = div_clk_out[ch];
            pv[k] = cfg_pending[ch];
`ifdef CLK_DIV_TICK_EN
            tv[k] = div_tick[ch];
`endif
            for (int j = 0; j < NUM_CH; j++)
                if (j != ch) others = others | div_clk_out[j];
        end
    endtask

    logic [63:0] ov, pv, tv;
    logic        others;

    initial begin
        rst_n     = 1'b0;
        ch_en     = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        step(3);
        check("reset_out", 64'(div_clk_out), 64'h0);
        check("reset_pending", 64'(cfg_pending), 64'h0);
        check("reset_ready", 64'(cfg_ready), 64'd1);
        rst_n = 1'b1;
        step(2);
        check("idle_out", 64'(div_clk_out), 64'h0);

        // Default div=8 on ch0: 8 low / 8 high, others held low
        ch_en = 4'b0001;
        capture(0, 32, ov, pv, tv, others);
        check("ch0_default_wave", ov, 64'h7F80_7F80);
        check("ch1_3_held_low", 64'(others), 64'h0);

        // Reprogram ch0 to div=2 in the middle of the high phase
        step(10);
        check("ch0_high_before_cfg", 64'(div_clk_out[0]), 64'd1);
        cfg_write(0, 2);
        check("ch0_pending_set", 64'(cfg_pending), 64'h1);
        check("ch0_ready_low", 64'(cfg_ready), 64'd0);
        capture(0, 12, ov, pv, tv, others);
        check("ch0_wave_old_then_new", ov, 64'hCCF);
        check("ch0_pending_clears_at_boundary", pv, 64'h00F);

        // Stopped ch1: divisor applies on the next edge
        cfg_write(1, 3);
        check("ch1_pending_set", 64'(cfg_pending[1]), 64'd1);
        step(1);
        check("ch1_pending_cleared", 64'(cfg_pending[1]), 64'd0);
        ch_en[1] = 1'b1;
        capture(1, 12, ov, pv, tv, others);
        check("ch1_div3_wave", ov, 64'h71C);

        // div=1 on ch2, then drop enable mid-high
        cfg_write(2, 1);
        step(1);
        check("ch2_pending_cleared", 64'(cfg_pending[2]), 64'd0);
        ch_en[2] = 1'b1;
        capture(2, 6, ov, pv, tv, others);
        check("ch2_div1_wave", ov, 64'h15);
        step(1);
        check("ch2_high_before_disable", 64'(div_clk_out[2]), 64'd1);
        ch_en[2] = 1'b0;
        step(1);
        check("ch2_low_after_disable", 64'(div_clk_out[2]), 64'd0);
        capture(2, 4, ov, pv, tv, others);
        check("ch2_stays_low", ov, 64'h0);

        // Async reset mid-period with ch3 pending
        ch_en[3] = 1'b1;
        step(9);
        cfg_write(3, 5);
        check("ch3_pending_before_reset", 64'(cfg_pending[3]), 64'd1);
        check("ch3_high_before_reset", 64'(div_clk_out[3]), 64'd1);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 64'(div_clk_out), 64'h0);
        check("async_reset_pending", 64'(cfg_pending), 64'h0);
        check("async_reset_ready", 64'(cfg_ready), 64'd1);
        @(negedge clk_50M);
        ch_en = 4'b1000;
        rst_n = 1'b1;
        capture(3, 17, ov, pv, tv, others);
        check("ch3_default_after_reset", ov, 64'h7F80);
        check("ch3_pending_lost", pv, 64'h0);

        // Reprogram ch3 to div=0: stops at the end of the next high phase
        cfg_write(3, 0);
        capture(3, 20, ov, pv, tv, others);
        check("ch3_div0_wave", ov, 64'h1FE0);
        check("ch3_div0_pending", pv, 64'h1FFF);

`ifdef CLK_DIV_TICK_EN
        cfg_write(1, 5);
        step(1);
        ch_en[1] = 1'b1;
        capture(1, 30, ov, pv, tv, others);
        check("ch1_div5_wave", ov, 64'h1F07_C1F0);
        check("ch1_div5_tick", tv, 64'h0100_4010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
